// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;
  localparam int unsigned MDU_ITER  = 32;
  localparam int unsigned MDU_CNT_W = 6;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

  // Signed ops work on magnitudes and get their sign restored at the end.
  function automatic logic op_is_signed(input op_e f_op);
    return (f_op == MULT) || (f_op == DIV);
  endfunction

  function automatic logic op_is_div(input op_e f_op);
    return (f_op == DIV) || (f_op == DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit.
// One radix-2 step per RUN cycle (shift-add multiply, restoring divide) on
// operand magnitudes, followed by a single FIX cycle that restores signs,
// resolves divide-by-zero and commits the result to HI/LO.
module mult_div_unit
  import mdu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [MDU_WIDTH-1:0] a,
  input  logic [MDU_WIDTH-1:0] b,
  input  logic                 hi_we,
  input  logic                 lo_we,
  input  logic [MDU_WIDTH-1:0] wdata,
  output logic                 busy,
  output logic                 done,
  output logic [MDU_WIDTH-1:0] hi,
  output logic [MDU_WIDTH-1:0] lo
);

  localparam int unsigned W = MDU_WIDTH;
  localparam logic [MDU_CNT_W-1:0] CNT_LAST = MDU_CNT_W'(MDU_ITER - 1);

  // Control and architectural state
  state_e               state_q;
  op_e                  op_q;
  logic [MDU_CNT_W-1:0] cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic [W-1:0]         hi_q;
  logic [W-1:0]         lo_q;

  // Iteration datapath: work_q is {accumulator/remainder, multiplier/quotient}
  logic [2*W-1:0]       work_q;
  logic [W-1:0]         dvs_q;      // multiplicand or divisor magnitude
  logic [W-1:0]         a_q;        // raw dividend, returned in HI on divide by zero
  logic                 neg_main_q; // negate product or quotient in FIX
  logic                 neg_rem_q;  // negate remainder in FIX

  // Operand decode at acceptance
  op_e                  op_in;
  logic                 in_signed;
  logic                 in_div;
  logic [W-1:0]         mag_a;
  logic [W-1:0]         mag_b;
  logic [2*W-1:0]       load_work;
  logic [W-1:0]         load_dvs;

  // One iteration step
  logic [W:0]           sum;
  logic [W:0]           shifted;
  logic [W:0]           diff;
  logic [2*W-1:0]       step_work;

  // Final result formed in FIX
  logic [2*W-1:0]       prod;
  logic [W-1:0]         quo;
  logic [W-1:0]         rem;
  logic [W-1:0]         res_hi;
  logic [W-1:0]         res_lo;

  // Decode the incoming request into magnitudes and the initial work layout.
  // NOTE: every signal driven here gets a value on every path before any
  // branch, so no combinational path can hold a stale value (no latch).
  always_comb begin
    op_in     = op_e'(op);
    in_signed = op_is_signed(op_in);
    in_div    = op_is_div(op_in);
    mag_a     = (in_signed && a[W-1]) ? -a : a;
    mag_b     = (in_signed && b[W-1]) ? -b : b;
    load_work = {{W{1'b0}}, mag_b};
    load_dvs  = mag_a;
    if (in_div) begin
      load_work = {{W{1'b0}}, mag_a};
      load_dvs  = mag_b;
    end
  end

  // One radix-2 step: shift-add for multiply, restoring subtract for divide.
  always_comb begin
    sum       = {1'b0, work_q[2*W-1:W]} + {1'b0, dvs_q};
    shifted   = work_q[2*W-1:W-1];
    diff      = shifted - {1'b0, dvs_q};
    step_work = work_q;
    if (op_is_div(op_q)) begin
      // A borrow out of the trial subtraction means the divisor did not fit.
      if (diff[W]) begin
        step_work = {shifted[W-1:0], work_q[W-2:0], 1'b0};
      end else begin
        step_work = {diff[W-1:0], work_q[W-2:0], 1'b1};
      end
    end else begin
      // The carry of the partial sum shifts into the top of the product.
      if (work_q[0]) begin
        step_work = {sum, work_q[W-1:1]};
      end else begin
        step_work = {1'b0, work_q[2*W-1:1]};
      end
    end
  end

  // Sign correction and divide-by-zero handling for the committed result.
  always_comb begin
    prod   = neg_main_q ? -work_q : work_q;
    quo    = work_q[W-1:0];
    rem    = work_q[2*W-1:W];
    res_hi = prod[2*W-1:W];
    res_lo = prod[W-1:0];
    if (op_is_div(op_q)) begin
      if (dvs_q == '0) begin
        res_hi = a_q;
        res_lo = {W{1'b1}};
      end else begin
        res_hi = neg_rem_q  ? -rem : rem;
        res_lo = neg_main_q ? -quo : quo;
      end
    end
  end

  // Sequencer: accept in IDLE, iterate in RUN, commit in FIX.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      op_q       <= MULT;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      work_q     <= '0;
      dvs_q      <= '0;
      a_q        <= '0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // Direct writes land at the same edge a start is accepted; the
          // operation's result replaces them when it commits.
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start) begin
            op_q       <= op_in;
            a_q        <= a;
            dvs_q      <= load_dvs;
            work_q     <= load_work;
            neg_main_q <= in_signed & (a[W-1] ^ b[W-1]);
            neg_rem_q  <= in_signed & in_div & a[W-1];
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          work_q <= step_work;
          cnt_q  <= cnt_q + MDU_CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            busy_q  <= 1'b0;
            state_q <= FIX;
          end
        end
        FIX: begin
          hi_q    <= res_hi;
          lo_q    <= res_lo;
          done_q  <= 1'b1;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have rst, input, 1, reset: asynchronous assert, active-low, synchronous deassert at the module boundary.
REQ-003 SHALL have start, input, 1, request to begin an operation; sampled only when busy=0.
REQ-004 SHALL have op, input, 2, operation select from mdu_pkg: MULT=00, MULTU=01, DIV=10, DIVU=11.
REQ-005 SHALL have a, input, 32, multiplicand or dividend.
REQ-006 SHALL have b, input, 32, multiplier or divisor.
REQ-007 SHALL have hi_we / lo_we, input, 1 each, direct-write strobes (MTHI/MTLO).
REQ-008 SHALL have wdata, input, 32, data for hi_we/lo_we.
REQ-009 SHALL have busy, output, 1, an operation is in progress.
REQ-010 SHALL have done, output, 1, one-cycle pulse when HI/LO receive a result.
REQ-011 SHALL have hi / lo, output, 32 each, architectural HI/LO registers, read directly (MFHI/MFLO).

Function
REQ-012 SHALL use the states IDLE, RUN and FIX: IDLE->RUN on start; RUN->FIX after 32 iterations; FIX->IDLE unconditionally.
REQ-013 SHALL latch op, a and b in IDLE at edge E0 when start=1, and SHALL not sample them again until the next accepted start.
REQ-014 SHALL hold busy=1 from after E0 through the edge at which FIX is entered (E32).
REQ-015 SHALL write hi/lo at edge E33 and pulse done=1 for exactly the cycle following E33; a dependent read is valid from that cycle.
REQ-016 SHALL perform one radix-2 step per RUN cycle: shift-add for multiply, restoring subtract for divide.
REQ-017 For signed ops, SHALL operate on magnitudes and apply sign correction in FIX.
REQ-018 MULT SHALL produce {hi,lo} = 64-bit two's-complement product of signed a and b.
REQ-019 MULTU SHALL produce {hi,lo} = 64-bit product of unsigned a and b.
REQ-020 DIV SHALL produce lo = quotient truncated toward zero and hi = remainder carrying the dividend's sign.
REQ-021 DIVU SHALL produce lo = unsigned quotient and hi = unsigned remainder.
REQ-022 On divide by zero (DIV or DIVU), SHALL produce lo=32'hFFFFFFFF and hi=a, still with 34-cycle timing.
REQ-023 DIV 32'h80000000 / 32'hFFFFFFFF SHALL produce lo=32'h80000000 and hi=0.
REQ-024 SHALL ignore start while busy=1; no queuing.
REQ-025 SHALL ignore hi_we/lo_we while busy=1 or in FIX.
REQ-026 When idle, SHALL write hi/lo from wdata at the next edge on hi_we/lo_we; with both strobes set, both registers receive wdata.
REQ-027 With hi_we/lo_we and start in the same idle cycle, SHALL apply the write at E0; the result overwrites it at E33.
REQ-028 hi/lo SHALL change only at E33 of an operation or on an accepted direct write.

Reset
REQ-029 On rst=0, SHALL force state=IDLE, busy=0, done=0, hi=0, lo=0 and clear all iteration state, including mid-operation; the aborted operation SHALL not write hi/lo.
REQ-030 After rst deasserts, SHALL accept start on the first edge.

Structure
REQ-031 mdu_pkg SHALL hold the op enum, the state enum, MDU_WIDTH=32 and MDU_ITER=32.
REQ-032 SHALL be a single module with no sub-module; the iteration counter SHALL be 6 bits.

Verification
REQ-033 MULT a=b=FFFFFFFF -> done 34 cycles after start; hi=00000000, lo=00000001.
REQ-034 MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
REQ-035 DIV a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF; then DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
REQ-036 DIVU a=12345678, b=0 -> lo=FFFFFFFF, hi=12345678.
REQ-037 MTHI 0xA5A5A5A5 idle, then MULTU 3*5 with a second start and hi_we at cycle 10 -> second start and write ignored; final hi=0, lo=0000000F.
REQ-038 Reset pulsed at cycle 15 of a DIVU -> busy=0, hi=lo=0 immediately; no done pulse; a new MULTU 2*3 gives lo=6.
